// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
// Multi-read-port integer register file with a per-register pending-write
// scoreboard. It is used by the kamus-v decode/issue stage.
//
// Parameters
//   XLEN     : data width
//   NUM_REGS : architectural register count (power of 2); x0 reads as zero
//   NUM_RD   : number of read ports
//   AW       : derived address width
//
// Ports
//   clk_i, rst_ni     : clock (rising edge), asynchronous active-low reset
//   rd_en_i[p]        : read enable of port p
//   rd_addr_i         : port p address at [p*AW +: AW]
//   rd_data_o         : port p data at [p*XLEN +: XLEN]; registered, 1-cycle latency
//   rd_busy_o[p]      : busy flag of the register read on port p
//   wr_en_i/addr/data : writeback; clears the busy bit of the target register
//   iss_en_i/addr     : issue; sets the busy bit of the destination register
//   busy_vec_o        : the whole scoreboard, straight from the flops
//
// Build option
//   REGFILE_BYPASS_EN : when defined, a read that hits the register being
//                       written in the same cycle returns the new data. It
//                       also returns the post-edge busy bit.
module regfile_mp_sb #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_RD   = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_RD-1:0]      rd_en_i,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [XLEN-1:0]        wr_data_i,
  input  logic                   iss_en_i,
  input  logic [AW-1:0]          iss_addr_i,
  output logic [NUM_REGS-1:0]    busy_vec_o
);

  logic [XLEN-1:0]     regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic                wr_act;

  // x0 is never written, so regs_reg[0] stays at its reset value of zero.
  assign wr_act = wr_en_i && (wr_addr_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_act) begin
      regs_reg[wr_addr_i] <= wr_data_i;
    end
  end

  // The writeback clear is applied first and the issue set second. This way
  // a new producer issued in the same cycle as the old writeback keeps the
  // register busy.
  always_comb begin
    busy_next = busy_reg;
    if (wr_en_i) begin
      busy_next[wr_addr_i] = 1'b0;
    end
    if (iss_en_i) begin
      busy_next[iss_addr_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec_o = busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]   rd_addr;
      logic [XLEN-1:0] data_reg;
      logic [XLEN-1:0] data_next;
      logic            busy_rd_reg;
      logic            busy_rd_next;

      assign rd_addr = rd_addr_i[gi*AW +: AW];

      always_comb begin
`ifdef REGFILE_BYPASS_EN
        // busy_next already combines this cycle's writeback clear and issue
        // set. That makes it the post-edge busy value the reader should see.
        data_next    = (wr_act && (wr_addr_i == rd_addr)) ? wr_data_i : regs_reg[rd_addr];
        busy_rd_next = busy_next[rd_addr];
`else
        data_next    = regs_reg[rd_addr];
        busy_rd_next = busy_reg[rd_addr];
`endif
        if (rd_addr == '0) begin
          data_next    = '0;
          busy_rd_next = 1'b0;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          data_reg    <= '0;
          busy_rd_reg <= 1'b0;
        end else if (rd_en_i[gi]) begin
          data_reg    <= data_next;
          busy_rd_reg <= busy_rd_next;
        end
      end

      assign rd_data_o[gi*XLEN +: XLEN] = data_reg;
      assign rd_busy_o[gi]              = busy_rd_reg;
    end
  endgenerate

endmodule
